// File: rtl/vga_pkg.sv
// Shared constants and types for the TinyVGA PMOD receive path and its generators.
package vga_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int HS      = 656;
    localparam int VS      = 490;

    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    localparam logic [7:0] PMOD_IDLE = 8'h88;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_H_LOCKED = 2'd1,
        ST_LOCKED   = 2'd2
    } syncState_e;

    function automatic logic [5:0] unpackRgb(input logic [7:0] pmod);
        return {pmod[PMOD_R1], pmod[PMOD_R0], pmod[PMOD_G1],
                pmod[PMOD_G0], pmod[PMOD_B1], pmod[PMOD_B0]};
    endfunction

    function automatic logic [15:0] rotl1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Input register, sync edge detection, raster counters and lock state machine.
// hCnt/vCnt always describe the sample currently held in the input register.
module vga_sync_tracker
    import vga_pkg::*;
#(
    parameter int VGA_WIDTH     = 640,
    parameter int VGA_HEIGHT    = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vgaPmod_i,
    output logic [7:0] sample_o,
    output logic [9:0] hCnt_o,
    output logic [9:0] vCnt_o,
    output logic       locked_o,
    output logic       syncError_o
);

    localparam int H_TOT = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOT = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] HS_POS     = 10'(VGA_WIDTH + H_FRONT_PORCH);
    localparam logic [9:0] HS_POS_P1  = 10'(VGA_WIDTH + H_FRONT_PORCH + 1);
    localparam logic [9:0] HS_END     = 10'(VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [9:0] VS_POS     = 10'(VGA_HEIGHT + V_FRONT_PORCH);
    localparam logic [9:0] VS_POS_P1  = 10'(VGA_HEIGHT + V_FRONT_PORCH + 1);

    logic [7:0]  sample_q;
    logic        prevHs_q;
    logic        prevVs_q;
    logic [9:0]  hCnt_q, hCnt_d;
    logic [9:0]  vCnt_q, vCnt_d;
    syncState_e  state_q, state_d;
    logic        syncError;

    logic hsFall, hsRise, vsFall, hWrap, hViol, vViol;

    assign hsFall = prevHs_q & ~sample_q[PMOD_HSYNC];
    assign hsRise = ~prevHs_q & sample_q[PMOD_HSYNC];
    assign vsFall = prevVs_q & ~sample_q[PMOD_VSYNC];
    assign hWrap  = (hCnt_q == H_LAST);

    // A pulse that starts anywhere but HS, ends anywhere but HS_END, or is still low at HS_END is the wrong length or place
    assign hViol = (hsFall && (hCnt_q != HS_POS))
                || (hsRise && (hCnt_q != HS_END))
                || (!sample_q[PMOD_HSYNC] && (hCnt_q == HS_END));
    assign vViol = vsFall && (vCnt_q != VS_POS);

    // Next counter values and lock transitions; counters free-run and are realigned on lock
    always_comb begin
        state_d   = state_q;
        syncError = 1'b0;
        hCnt_d    = hWrap ? 10'd0 : hCnt_q + 10'd1;
        vCnt_d    = vCnt_q;
        if (hWrap) begin
            vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
        end
        case (state_q)
            ST_UNLOCKED: begin
                if (hsFall) begin
                    hCnt_d  = HS_POS_P1;
                    state_d = ST_H_LOCKED;
                end
            end
            ST_H_LOCKED: begin
                if (hViol) begin
                    state_d = ST_UNLOCKED;
                end else if (vsFall) begin
                    vCnt_d  = hWrap ? VS_POS_P1 : VS_POS;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (hViol || vViol) begin
                    syncError = 1'b1;
                    state_d   = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Register the bus sample, the previous sync levels, the counters and the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= PMOD_IDLE;
            prevHs_q <= 1'b1;
            prevVs_q <= 1'b1;
            hCnt_q   <= 10'd0;
            vCnt_q   <= 10'd0;
            state_q  <= ST_UNLOCKED;
        end else begin
            sample_q <= vgaPmod_i;
            prevHs_q <= sample_q[PMOD_HSYNC];
            prevVs_q <= sample_q[PMOD_VSYNC];
            hCnt_q   <= hCnt_d;
            vCnt_q   <= vCnt_d;
            state_q  <= state_d;
        end
    end

    assign sample_o    = sample_q;
    assign hCnt_o      = hCnt_q;
    assign vCnt_o      = vCnt_q;
    assign locked_o    = (state_q == ST_LOCKED);
    assign syncError_o = syncError;

endmodule

// File: rtl/vga_capture.sv
// TinyVGA PMOD capture: pixel coordinate/colour recovery plus a per-frame signature.
// Everything here sits one register after the sync tracker so outputs are aligned.
module vga_capture
    import vga_pkg::*;
#(
    parameter int VGA_WIDTH     = 640,
    parameter int VGA_HEIGHT    = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_pmod,
    output logic        locked,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [5:0]  rgb,
    output logic        frame_done,
    output logic [15:0] frame_checksum,
    output logic        sync_error
);

    localparam logic [9:0] X_END  = 10'(VGA_WIDTH);
    localparam logic [9:0] Y_END  = 10'(VGA_HEIGHT);
    localparam logic [9:0] X_LAST = 10'(VGA_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(VGA_HEIGHT - 1);

    logic [7:0]  sample;
    logic [9:0]  hCnt, vCnt;
    logic        trkLocked, trkError;

    vga_sync_tracker #(
        .VGA_WIDTH     (VGA_WIDTH),
        .VGA_HEIGHT    (VGA_HEIGHT),
        .H_FRONT_PORCH (H_FRONT_PORCH),
        .H_SYNC_PULSE  (H_SYNC_PULSE),
        .H_BACK_PORCH  (H_BACK_PORCH),
        .V_FRONT_PORCH (V_FRONT_PORCH),
        .V_SYNC_PULSE  (V_SYNC_PULSE),
        .V_BACK_PORCH  (V_BACK_PORCH)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .vgaPmod_i   (vga_pmod),
        .sample_o    (sample),
        .hCnt_o      (hCnt),
        .vCnt_o      (vCnt),
        .locked_o    (trkLocked),
        .syncError_o (trkError)
    );

    logic        lockedNow, pvNow, lastAccept;
    logic [5:0]  rgbNow;
    logic        locked_q, pixelValid_q, frameDone_q, syncError_q, frameOk_q, frameOk_d;
    logic [9:0]  pixelX_q, pixelY_q;
    logic [5:0]  rgb_q;
    logic [15:0] acc_q, acc_d, checksum_q;

    // A sample that trips a sync violation is already treated as unlocked
    assign lockedNow  = trkLocked && !trkError;
    assign pvNow      = lockedNow && (hCnt < X_END) && (vCnt < Y_END);
    assign rgbNow     = unpackRgb(sample);
    assign lastAccept = pixelValid_q && (pixelX_q == X_LAST) && (pixelY_q == Y_LAST) && frameOk_q;

    // Signature accumulation; a frame is only credited if capture started at (0,0) and stayed locked
    always_comb begin
        acc_d     = acc_q;
        frameOk_d = frameOk_q;
        if (lastAccept) begin
            acc_d     = 16'd0;
            frameOk_d = 1'b0;
        end
        if (!lockedNow) begin
            acc_d     = 16'd0;
            frameOk_d = 1'b0;
        end else if (pvNow) begin
            if ((hCnt == 10'd0) && (vCnt == 10'd0)) begin
                acc_d     = {10'd0, rgbNow};
                frameOk_d = 1'b1;
            end else begin
                acc_d = rotl1(acc_d) ^ {10'd0, rgbNow};
            end
        end
    end

    // Output register stage plus checksum capture one cycle after the last pixel leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q     <= 1'b0;
            pixelValid_q <= 1'b0;
            pixelX_q     <= 10'd0;
            pixelY_q     <= 10'd0;
            rgb_q        <= 6'd0;
            syncError_q  <= 1'b0;
            frameDone_q  <= 1'b0;
            checksum_q   <= 16'd0;
            acc_q        <= 16'd0;
            frameOk_q    <= 1'b0;
        end else begin
            locked_q     <= lockedNow;
            pixelValid_q <= pvNow;
            pixelX_q     <= hCnt;
            pixelY_q     <= vCnt;
            rgb_q        <= rgbNow;
            syncError_q  <= trkError;
            frameDone_q  <= lastAccept;
            if (lastAccept) begin
                checksum_q <= acc_q;
            end
            acc_q        <= acc_d;
            frameOk_q    <= frameOk_d;
        end
    end

    assign locked         = locked_q;
    assign pixel_valid    = pixelValid_q;
    assign pixel_x        = pixelX_q;
    assign pixel_y        = pixelY_q;
    assign rgb            = rgb_q;
    assign sync_error     = syncError_q;
    assign frame_done     = frameDone_q;
    assign frame_checksum = checksum_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced raster so several whole frames fit in a short run.
module tb_vga_capture;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int HFP  = 2;
    localparam int HSP  = 4;
    localparam int HBP  = 3;
    localparam int VFP  = 2;
    localparam int VSP  = 2;
    localparam int VBP  = 3;
    localparam int HT   = W + HFP + HSP + HBP;
    localparam int VT   = H + VFP + VSP + VBP;
    localparam int HSPOS = W + HFP;
    localparam int VSPOS = H + VFP;
    localparam logic [9:0] XL = 10'(W - 1);
    localparam logic [9:0] YL = 10'(H - 1);

    logic        clk;
    logic        rst_n;
    logic [7:0]  vga_pmod;
    logic        locked, pixel_valid, frame_done, sync_error;
    logic [9:0]  pixel_x, pixel_y;
    logic [5:0]  rgb;
    logic [15:0] frame_checksum;

    int total;
    int bad;
    int curMode;
    int pvCount;
    bit prevLast;
    bit errFollow;
    logic [15:0] doneQ[$];
    bit          errQ[$];

    vga_capture #(
        .VGA_WIDTH(W), .VGA_HEIGHT(H),
        .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_pmod(vga_pmod),
        .locked(locked), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb(rgb),
        .frame_done(frame_done), .frame_checksum(frame_checksum),
        .sync_error(sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] colourAt(input int mode, input int x, input int y);
        if (mode == 1 && x == 0 && y == 0) return 6'h3F;
        if (mode == 2 && x == W - 1 && y == H - 1) return 6'h15;
        return 6'h00;
    endfunction

    function automatic logic [7:0] packPmod(input logic hs, input logic vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    // Drives one raster frame; pushes the expected signature and any expected sync errors as it goes
    task automatic applyStimulus(input int mode, input bit expectDone, input int earlyLine,
                                 input int shortLine, input int resetLine, input bit probeLock);
        logic [15:0] acc;
        logic        hs, vs;
        logic [5:0]  c;
        curMode = mode;
        acc = 16'd0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                hs = !(h >= HSPOS && h < HSPOS + HSP);
                if (v == earlyLine) hs = !(h >= HSPOS - 1 && h < HSPOS + HSP);
                if (v == shortLine) hs = !(h >= HSPOS && h < HSPOS + HSP - 1);
                vs = !(v >= VSPOS && v < VSPOS + VSP);
                c  = (h < W && v < H) ? colourAt(mode, h, v) : 6'd0;
                vga_pmod = packPmod(hs, vs, c);
                if (h < W && v < H) acc = {acc[14:0], acc[15]} ^ {10'd0, c};
                if (expectDone && h == W - 1 && v == H - 1) doneQ.push_back(acc);
                if ((v == earlyLine && h == HSPOS - 1) || (v == shortLine && h == HSPOS + HSP - 1))
                    errQ.push_back(1'b1);
                if (probeLock && v == VSPOS - 1 && h == 0)
                    checkOutput("lockedBeforeVs", 32'(locked), 32'd0);
                if (v == resetLine && h == W / 2) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("midRstLocked", 32'(locked), 32'd0);
                    checkOutput("midRstValid", 32'(pixel_valid), 32'd0);
                    checkOutput("midRstX", 32'(pixel_x), 32'd0);
                    checkOutput("midRstY", 32'(pixel_y), 32'd0);
                    checkOutput("midRstRgb", 32'(rgb), 32'd0);
                    checkOutput("midRstDone", 32'(frame_done), 32'd0);
                    checkOutput("midRstSum", 32'(frame_checksum), 32'd0);
                    checkOutput("midRstErr", 32'(sync_error), 32'd0);
                end
                if (v == resetLine && h == W / 2 + 2) rst_n = 1'b1;
            end
        end
    endtask

    // Scoreboard side: pops expected signatures/errors as the DUT reports them
    always @(negedge clk) begin
        if (errFollow) begin
            checkOutput("lockedAfterErr", 32'(locked), 32'd0);
            checkOutput("validAfterErr", 32'(pixel_valid), 32'd0);
            errFollow = 1'b0;
        end
        if (sync_error) begin
            checkOutput("errExpected", 32'(errQ.size() > 0), 32'd1);
            if (errQ.size() > 0) void'(errQ.pop_front());
            errFollow = 1'b1;
        end
        if (frame_done) begin
            checkOutput("doneExpected", 32'(doneQ.size() > 0), 32'd1);
            if (doneQ.size() > 0) checkOutput("checksum", 32'(frame_checksum), 32'(doneQ.pop_front()));
            checkOutput("doneTiming", 32'(prevLast), 32'd1);
            checkOutput("pixCount", 32'(pvCount), 32'(W * H));
        end
        if (pixel_valid) begin
            if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
                pvCount = 1;
                checkOutput("rgbFirst", 32'(rgb), 32'(colourAt(curMode, 0, 0)));
            end else begin
                pvCount++;
            end
            if (pixel_x == XL && pixel_y == YL)
                checkOutput("rgbLast", 32'(rgb), 32'(colourAt(curMode, W - 1, H - 1)));
        end
        prevLast = pixel_valid && (pixel_x == XL) && (pixel_y == YL);
    end

    initial begin
        total = 0;
        bad = 0;
        curMode = 0;
        pvCount = 0;
        prevLast = 1'b0;
        errFollow = 1'b0;
        rst_n = 1'b0;
        vga_pmod = 8'h88;
        repeat (3) @(negedge clk);
        checkOutput("rstLocked", 32'(locked), 32'd0);
        checkOutput("rstValid", 32'(pixel_valid), 32'd0);
        checkOutput("rstX", 32'(pixel_x), 32'd0);
        checkOutput("rstY", 32'(pixel_y), 32'd0);
        checkOutput("rstRgb", 32'(rgb), 32'd0);
        checkOutput("rstDone", 32'(frame_done), 32'd0);
        checkOutput("rstSum", 32'(frame_checksum), 32'd0);
        checkOutput("rstErr", 32'(sync_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] lock-up frame");
        applyStimulus(0, 1'b0, -1, -1, -1, 1'b1);
        checkOutput("lockedAfterVs", 32'(locked), 32'd1);
        $display("[TB] black, first pixel white, last pixel 0x15");
        applyStimulus(0, 1'b1, -1, -1, -1, 1'b0);
        applyStimulus(1, 1'b1, -1, -1, -1, 1'b0);
        applyStimulus(2, 1'b1, -1, -1, -1, 1'b0);
        $display("[TB] early hsync, then relocked frame");
        applyStimulus(0, 1'b0, 3, -1, -1, 1'b0);
        applyStimulus(0, 1'b1, -1, -1, -1, 1'b0);
        $display("[TB] short hsync, then relocked frame");
        applyStimulus(0, 1'b0, -1, 2, -1, 1'b0);
        applyStimulus(2, 1'b1, -1, -1, -1, 1'b0);
        $display("[TB] mid-frame reset, then relocked frame");
        applyStimulus(1, 1'b0, -1, -1, H / 2, 1'b0);
        applyStimulus(2, 1'b1, -1, -1, -1, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("donePending", 32'(doneQ.size()), 32'd0);
        checkOutput("errPending", 32'(errQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive side of the TinyVGA PMOD video interface: samples the 8-bit `vga_pmod` bus driven by our graphics generators and locks onto hsync/vsync. It recovers pixel coordinates and the 6-bit colour, and produces a per-frame signature. It is used in simulation benches and in on-chip loopback self-test to check frame content and sync timing without a monitor.

## Interface

**Parameters**
- `VGA_WIDTH`, default 640: active pixels per line.
- `VGA_HEIGHT`, default 480: active lines per frame.
- `H_FRONT_PORCH`, default 16; `H_SYNC_PULSE`, default 96; `H_BACK_PORCH`, default 48: horizontal timing in pixels.
- `V_FRONT_PORCH`, default 10; `V_SYNC_PULSE`, default 2; `V_BACK_PORCH`, default 33: vertical timing in lines.

**Ports**
- `clk` in 1: pixel clock. One clock is the only clock in the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vga_pmod` in 8: `{hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}`. Syncs are active-low.
- `locked` out 1: the receiver is aligned to both syncs.
- `pixel_valid` out 1: the current `rgb`, `pixel_x` and `pixel_y` are an active-area pixel.
- `pixel_x` out 10: horizontal position of the output pixel.
- `pixel_y` out 10: line number of the output pixel.
- `rgb` out 6: `{r[1], r[0], g[1], g[0], b[1], b[0]}`.
- `frame_done` out 1: single-cycle pulse when a full frame has been captured.
- `frame_checksum` out 16: signature of the last complete frame.
- `sync_error` out 1: single-cycle pulse on a timing violation while locked.

## Operation

**Input stage**
- `vga_pmod` is registered once; the register resets to 8'h88 (both syncs high).
- An edge is a falling edge between consecutive registered samples.

**Counters**
- `h_cnt` runs from 0 to H_TOTAL-1 and wraps.
- `v_cnt` increments on each `h_cnt` wrap and wraps from V_TOTAL-1 to 0.
- `h_cnt` is the position of the sample currently in the input register.
- On an hsync fall, that sample is position HS = VGA_WIDTH+H_FRONT_PORCH (656).
- On a vsync fall, `v_cnt` becomes VS = VGA_HEIGHT+V_FRONT_PORCH (490); `h_cnt` is unaffected.

**State machine: UNLOCKED, H_LOCKED, LOCKED**
- UNLOCKED: on an hsync fall, load `h_cnt`←HS+1 (next cycle) and go to H_LOCKED.
- H_LOCKED:
  - Each hsync fall must coincide with predicted `h_cnt`==HS.
  - Each hsync low run must last exactly H_SYNC_PULSE samples.
  - Any violation returns to UNLOCKED with no `sync_error`.
  - The first vsync fall loads `v_cnt`←VS and goes to LOCKED.
- LOCKED:
  - The hsync checks above still apply.
  - A vsync fall must coincide with predicted `v_cnt`==VS.
  - Any violation pulses `sync_error`, clears `locked` and the accumulator, and returns to UNLOCKED.
  - If an hsync fall and a vsync fall arrive in the same cycle, both checks apply and one error pulse is raised.
- `locked`=1 only in LOCKED.

**Pixel output**
- `pixel_valid`=`locked` && `h_cnt`<VGA_WIDTH && `v_cnt`<VGA_HEIGHT, evaluated for the registered sample.
- Outside the active area, `rgb` is still driven from the bus but is don't-care.

**Checksum**
- The accumulator `acc` is 16 bits.
- On each valid pixel: `acc`←rotl1(`acc`) ^ {10'b0, `rgb`}.
- When the pixel (VGA_WIDTH-1, VGA_HEIGHT-1) has been accepted, the following happens one cycle later:
  - `frame_checksum`←final `acc`.
  - `frame_done` pulses.
  - `acc`←0.
- A frame counts only if LOCKED held from pixel (0,0) through the last pixel.
- A partial first frame after lock produces no `frame_done`; `acc` is cleared at (0,0).

## Timing

- Latency: `vga_pmod` at cycle n appears on `rgb`, `pixel_x`, `pixel_y` and `pixel_valid` at cycle n+2 (input register plus output register).
- `sync_error`, `frame_done` and `locked` are registered and aligned with the pixel outputs.
- `frame_done` asserts the cycle after the last valid pixel's `pixel_valid`.
- Reset values:
  - All outputs 0.
  - State UNLOCKED; counters 0; `acc` 0.
- Asserting reset mid-frame clears everything immediately (async). After release, capture relocks from the next hsync fall.

## Structure

- Package `vga_pkg`:
  - H_TOTAL and V_TOTAL.
  - HS and VS start positions.
  - Pmod bit indices.
  - State enum.
  - These are shared with the generators.
- One sub-module, `vga_sync_tracker`:
  - Contains the input register, edge detect, counters, FSM and checks.
  - Outputs `h_cnt`, `v_cnt`, `locked` and `sync_error`.
- The top level adds the colour unpack, the output register and the checksum.

## Test plan

- Bench-modelled 640×480 source, all black, two frames → `locked` rises after the first vsync fall; second frame `frame_done`=1 with `frame_checksum`=16'h0000; no `sync_error`.
- Frame black except `vga_pmod`=8'hFF at (0,0) → `frame_checksum`=16'h801F.
- Frame black except `rgb`=6'h15 at (639,479) → `frame_checksum`=16'h0015; `frame_done` exactly one cycle after that pixel's `pixel_valid`.
- While locked, move one hsync fall one cycle early → one `sync_error` pulse, `locked`=0, `pixel_valid`=0; relock after the next vsync fall, with no `frame_done` for the disrupted frame.
- Hsync low for 95 cycles while locked → `sync_error` pulse, UNLOCKED.
- Assert `rst_n` low at (320,240) → all outputs 0 within the same cycle; after release, the next full frame yields the correct checksum.
